// File: rtl/uart_packet_tx_if.sv
// Byte-stream bundle between a payload source, the packet framer and the UART transmit handshake.
// The slave modport is the framer's view; the master modport is the surrounding logic's view.
interface uart_packet_tx_if;
    logic [7:0] pkt_type;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       payload_ready;
    logic       payload_last;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       busy;
    logic       overflow;

    modport master (
        output pkt_type, payload_data, payload_valid, payload_last, tx_data_ready,
        input  payload_ready, tx_data, tx_data_valid, busy, overflow
    );

    modport slave (
        input  pkt_type, payload_data, payload_valid, payload_last, tx_data_ready,
        output payload_ready, tx_data, tx_data_valid, busy, overflow
    );
endinterface

// File: rtl/uart_packet_tx.sv
// Packet framer: buffers a payload, then emits SYNC, TYPE, LEN, payload, CHECKSUM as a byte stream.
// The checksum is the mod-256 sum of TYPE, LEN and the payload bytes.
module uart_packet_tx #(
    parameter int unsigned MAX_PAYLOAD = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input logic             clk,
    input logic             reset,
    uart_packet_tx_if.slave bus
);
    localparam int unsigned IdxW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0]  MaxCnt      = 8'(MAX_PAYLOAD);
    localparam bit          CanOverflow = (MAX_PAYLOAD > 1);

    typedef enum logic [2:0] {
        StCollect, StSendSync, StSendType, StSendLen, StSendPayload, StSendCsum
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] rd_idx_q, rd_idx_d;
    logic [7:0] type_q, type_d;
    logic [7:0] csum_q, csum_d;
    logic       busy_q, busy_d;
    logic       ovf_q, ovf_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       wr_en;
    logic       accept;
    logic       tx_hs;
    logic [7:0] pl_mem_q [MAX_PAYLOAD];

    // Reset gates ready combinationally so no byte is offered acceptance while reset is held.
    assign bus.payload_ready = (state_q == StCollect) && !reset;
    assign accept            = bus.payload_valid && bus.payload_ready;
    assign tx_hs             = tx_valid_q && bus.tx_data_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_idx_d   = rd_idx_q;
        type_d     = type_q;
        csum_d     = csum_q;
        busy_d     = busy_q;
        ovf_d      = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wr_en      = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 8'd1;
                    busy_d  = 1'b1;
                    // Running sum starts from TYPE; LEN is folded in when the checksum is sent.
                    if (count_q == 8'd0) begin
                        type_d = bus.pkt_type;
                        csum_d = bus.pkt_type + bus.payload_data;
                    end else begin
                        csum_d = csum_q + bus.payload_data;
                    end
                    if (bus.payload_last || (count_d == MaxCnt)) begin
                        state_d    = StSendSync;
                        tx_data_d  = SYNC_BYTE;
                        tx_valid_d = 1'b1;
                        ovf_d      = CanOverflow && !bus.payload_last;
                    end
                end
            end
            StSendSync: begin
                if (tx_hs) begin
                    state_d   = StSendType;
                    tx_data_d = type_q;
                end
            end
            StSendType: begin
                if (tx_hs) begin
                    state_d   = StSendLen;
                    tx_data_d = count_q;
                end
            end
            StSendLen: begin
                if (tx_hs) begin
                    state_d   = StSendPayload;
                    tx_data_d = pl_mem_q[0];
                    rd_idx_d  = 8'd1;
                end
            end
            StSendPayload: begin
                if (tx_hs) begin
                    if (rd_idx_q == count_q) begin
                        state_d   = StSendCsum;
                        tx_data_d = csum_q + count_q;
                    end else begin
                        tx_data_d = pl_mem_q[rd_idx_q[IdxW-1:0]];
                        rd_idx_d  = rd_idx_q + 8'd1;
                    end
                end
            end
            StSendCsum: begin
                if (tx_hs) begin
                    state_d    = StCollect;
                    count_d    = 8'd0;
                    rd_idx_d   = 8'd0;
                    csum_d     = 8'd0;
                    busy_d     = 1'b0;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            count_q    <= 8'd0;
            rd_idx_q   <= 8'd0;
            type_q     <= 8'd0;
            csum_q     <= 8'd0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            type_q     <= type_d;
            csum_q     <= csum_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pl_mem_q[count_q[IdxW-1:0]] <= bus.payload_data;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_valid_q;
    assign bus.busy          = busy_q;
    assign bus.overflow      = ovf_q;
endmodule
